// File: rtl/meta_extract.sv
// Metadata frame extractor: validates single-flit frames and
// queues the recovered metadata in a small FWFT FIFO.
module meta_extract #(
  parameter int          META_W       = 252,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          AF_THRESH    = 2,
  parameter logic [47:0] EXP_DST_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] EXP_SRC_MAC  = 48'h02_00_00_00_00_02,
  parameter logic [15:0] EXP_ETH_META = 16'h88B5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [5:0]        in_empty,
  output logic              in_ready,
  output logic              in_almost_full,
  output logic [META_W-1:0] out_meta_data,
  output logic              out_meta_valid,
  input  logic              out_meta_ready,
  output logic [31:0]       stat_good,
  output logic [31:0]       stat_bad_hdr,
  output logic [31:0]       stat_bad_frame
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_DROP
  } state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [META_W-1:0] r_mem [FIFO_DEPTH];
  logic [31:0]       r_good;
  logic [31:0]       r_bad_hdr;
  logic [31:0]       r_bad_frame;

  logic w_acc;
  logic w_pop;
  logic w_push;
  logic w_inc_good;
  logic w_inc_hdr;
  logic w_inc_frm;
  logic w_hdr_ok;
  logic w_unused;

  assign in_ready = rst && (r_count != CW'(FIFO_DEPTH));
  assign in_almost_full = (r_count >= CW'(AF_THRESH));
  assign out_meta_valid = (r_count != '0);
  assign out_meta_data = r_mem[r_rd_ptr];
  assign stat_good = r_good;
  assign stat_bad_hdr = r_bad_hdr;
  assign stat_bad_frame = r_bad_frame;

  assign w_acc = in_valid && in_ready;
  assign w_pop = out_meta_valid && out_meta_ready;
  assign w_hdr_ok = (in_data[511:400] ==
                     {EXP_DST_MAC, EXP_SRC_MAC, EXP_ETH_META});
  assign w_unused = ^in_data[147:0];

  // Frame classification and framing state tracking
  always_comb begin
    w_nstate = r_state;
    w_push = 1'b0;
    w_inc_good = 1'b0;
    w_inc_hdr = 1'b0;
    w_inc_frm = 1'b0;
    if (w_acc) begin
      if (r_state == S_IDLE || in_sop) begin
        unique case (1'b1)
          (in_sop && in_eop): begin
            w_nstate = S_IDLE;
            if (in_empty != '0) begin
              w_inc_frm = 1'b1;
            end else if (w_hdr_ok) begin
              w_push = 1'b1;
              w_inc_good = 1'b1;
            end else begin
              w_inc_hdr = 1'b1;
            end
          end
          (in_sop && !in_eop): begin
            w_inc_frm = 1'b1;
            w_nstate = S_DROP;
          end
          default: begin
            w_inc_frm = 1'b1;
            w_nstate = in_eop ? S_IDLE : S_DROP;
          end
        endcase
      end else if (in_eop) begin
        w_nstate = S_IDLE;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage, no reset needed since occupancy gates it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data[META_W+147:148];
  end

  // Saturating frame statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_good <= '0;
      r_bad_hdr <= '0;
      r_bad_frame <= '0;
    end else begin
      if (w_inc_good && r_good != '1)
        r_good <= r_good + 1'b1;
      if (w_inc_hdr && r_bad_hdr != '1)
        r_bad_hdr <= r_bad_hdr + 1'b1;
      if (w_inc_frm && r_bad_frame != '1)
        r_bad_frame <= r_bad_frame + 1'b1;
    end
  end

endmodule

// File: tb/tb_meta_extract.sv
// Directed bench for meta_extract: classification table plus
// backpressure and async reset sequences.
module tb_meta_extract;

  localparam logic [47:0] DST = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_02;
  localparam logic [15:0] ETH = 16'h88B5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [511:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [5:0]   in_empty = '0;
  logic         in_ready;
  logic         in_almost_full;
  logic [251:0] out_meta_data;
  logic         out_meta_valid;
  logic         out_meta_ready = 1'b0;
  logic [31:0]  stat_good;
  logic [31:0]  stat_bad_hdr;
  logic [31:0]  stat_bad_frame;

  int n_checks = 0;
  int n_err = 0;

  meta_extract dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_empty       (in_empty),
    .in_ready       (in_ready),
    .in_almost_full (in_almost_full),
    .out_meta_data  (out_meta_data),
    .out_meta_valid (out_meta_valid),
    .out_meta_ready (out_meta_ready),
    .stat_good      (stat_good),
    .stat_bad_hdr   (stat_bad_hdr),
    .stat_bad_frame (stat_bad_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic         flip;
    logic [251:0] meta;
    logic         push;
    int           g;
    int           h;
    int           f;
  } vec_t;

  vec_t tbl [14];
  logic [251:0] popped [$];

  function automatic logic [511:0] mk(logic [251:0] m, logic flip);
    logic [47:0] d;
    d = DST ^ {47'b0, flip};
    return {d, SRC, ETH, m, 148'b0};
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(logic s, logic e, logic [5:0] em,
                      logic [511:0] d);
    in_sop = s;
    in_eop = e;
    in_empty = em;
    in_data = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_stats(string nm, int g, int h, int f);
    chk({nm, "_good"}, 256'(stat_good), 256'(g));
    chk({nm, "_hdr"}, 256'(stat_bad_hdr), 256'(h));
    chk({nm, "_frame"}, 256'(stat_bad_frame), 256'(f));
  endtask

  initial begin
    tbl[0]  = '{1, 1, 6'd0, 0, 252'h1234, 1, 1, 0, 0};
    tbl[1]  = '{1, 1, 6'd0, 1, 252'h9, 0, 1, 1, 0};
    tbl[2]  = '{1, 1, 6'd4, 0, 252'h9, 0, 1, 1, 1};
    tbl[3]  = '{1, 0, 6'd0, 0, 252'h9, 0, 1, 1, 2};
    tbl[4]  = '{0, 0, 6'd0, 0, 252'h9, 0, 1, 1, 2};
    tbl[5]  = '{0, 1, 6'd0, 0, 252'h9, 0, 1, 1, 2};
    tbl[6]  = '{1, 1, 6'd0, 0, 252'h7, 1, 2, 1, 2};
    tbl[7]  = '{1, 0, 6'd0, 0, 252'h9, 0, 2, 1, 3};
    tbl[8]  = '{1, 1, 6'd0, 0, 252'h8, 1, 3, 1, 3};
    tbl[9]  = '{0, 1, 6'd0, 0, 252'h9, 0, 3, 1, 4};
    tbl[10] = '{1, 1, 6'd0, 0, 252'h55, 1, 4, 1, 4};
    tbl[11] = '{0, 0, 6'd0, 0, 252'h9, 0, 4, 1, 5};
    tbl[12] = '{0, 1, 6'd0, 0, 252'h9, 0, 4, 1, 5};
    tbl[13] = '{1, 1, 6'd2, 1, 252'h9, 0, 4, 1, 6};

    // reset state
    #2;
    chk("rst_valid", 256'(out_meta_valid), 256'(0));
    chk("rst_ready", 256'(in_ready), 256'(0));
    chk("rst_af", 256'(in_almost_full), 256'(0));
    chk_stats("rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 256'(in_ready), 256'(1));

    // classification table, consumer always ready
    out_meta_ready = 1'b1;
    foreach (tbl[i]) begin
      beat(tbl[i].sop, tbl[i].eop, tbl[i].empty,
           mk(tbl[i].meta, tbl[i].flip));
      chk($sformatf("v%0d_valid", i), 256'(out_meta_valid),
          256'(tbl[i].push));
      if (tbl[i].push)
        chk($sformatf("v%0d_data", i), 256'(out_meta_data),
            256'(tbl[i].meta));
      chk_stats($sformatf("v%0d", i), tbl[i].g, tbl[i].h, tbl[i].f);
    end
    @(posedge clk);
    #1;
    chk("drain_valid", 256'(out_meta_valid), 256'(0));

    // backpressure: fill the FIFO with 1..4, frame 5 must stall
    out_meta_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fill%0d_ready", k), 256'(in_ready), 256'(1));
      beat(1, 1, 6'd0, mk(252'(k), 0));
      chk($sformatf("fill%0d_af", k), 256'(in_almost_full),
          256'(k >= 2));
    end
    chk("full_ready", 256'(in_ready), 256'(0));
    in_sop = 1'b1;
    in_eop = 1'b1;
    in_empty = '0;
    in_data = mk(252'd5, 0);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_good", 256'(stat_good), 256'(8));
    chk("stall_head", 256'(out_meta_data), 256'(1));
    out_meta_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (out_meta_valid) popped.push_back(out_meta_data);
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_npop", 256'(popped.size()), 256'(5));
    for (int k = 0; k < 5 && k < popped.size(); k++)
      chk($sformatf("bp_pop%0d", k), 256'(popped[k]), 256'(k + 1));
    chk("bp_good", 256'(stat_good), 256'(9));
    chk("bp_af", 256'(in_almost_full), 256'(0));

    // async reset with 3 queued and FSM in DROP
    out_meta_ready = 1'b0;
    for (int k = 0; k < 3; k++) beat(1, 1, 6'd0, mk(252'hA0, 0));
    beat(1, 0, 6'd0, mk(252'hA1, 0));
    chk("pre_rst_af", 256'(in_almost_full), 256'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 256'(out_meta_valid), 256'(0));
    chk("arst_ready", 256'(in_ready), 256'(0));
    chk("arst_af", 256'(in_almost_full), 256'(0));
    chk_stats("arst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_meta_ready = 1'b1;
    beat(0, 1, 6'd0, mk(252'hA2, 0));
    chk_stats("stray", 0, 0, 1);
    chk("stray_valid", 256'(out_meta_valid), 256'(0));
    beat(1, 1, 6'd0, mk(252'hABC, 0));
    chk("after_valid", 256'(out_meta_valid), 256'(1));
    chk("after_data", 256'(out_meta_data), 256'(252'hABC));
    chk_stats("after", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/meta_extract.md
Name: meta_extract

Overview:
- Receive-side counterpart of the metadata frame generator.
- Consumes the 512-bit Avalon-ST metadata frames that the generator emits: single-flit, sop=eop=1, empty=0, laid out as {DST_MAC, SRC_MAC, ETH_META, metadata, 148'b0}.
- Validates the frame header and framing, and recovers metadata_t into a small FWFT FIFO for the downstream consumer.
- Keeps saturating statistics of good and dropped frames.

Parameters:
- META_W, 252, metadata_t width; equals 512-48-48-16-148.
- FIFO_DEPTH, 4, metadata FIFO entries; power of two, ≥2.
- AF_THRESH, 2, occupancy at or above which in_almost_full asserts; 1..FIFO_DEPTH.
- EXP_DST_MAC, DST_MAC, expected in_data[511:464].
- EXP_SRC_MAC, SRC_MAC, expected in_data[463:416].
- EXP_ETH_META, ETH_META, expected in_data[415:400].

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  512  frame beat.
- in_valid  in  1  beat valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_empty  in  6  empty bytes on eop beat.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_almost_full  out  1  FIFO occupancy ≥ AF_THRESH.
- out_meta_data  out  META_W  = in_data[META_W+147:148] of head frame.
- out_meta_valid  out  1  FIFO non-empty.
- out_meta_ready  in  1  pop when out_meta_valid&&out_meta_ready.
- stat_good  out  32  frames delivered to FIFO.
- stat_bad_hdr  out  32  single-flit frames with header mismatch.
- stat_bad_frame  out  32  framing errors (multi-flit, stray, nonzero empty).

Behaviour:
- Reset (rst=0, async): FIFO count=0, pointers=0, state=IDLE, all stats=0.
- Reset outputs: out_meta_valid=0, in_ready=0, in_almost_full=0.
- in_ready = rst && (count != FIFO_DEPTH). Combinational from registered count; no dependence on in_valid.
- Accept = in_valid && in_ready. Non-accepted cycles change nothing except pops.
- FSM states: IDLE, DROP.
- IDLE, accepted beat with sop&&eop:
  - empty==0 and header == {EXP_DST_MAC, EXP_SRC_MAC, EXP_ETH_META}: push metadata, stat_good++.
  - empty!=0: discard, stat_bad_frame++. Empty is checked first; a nonzero-empty frame is not also counted as bad_hdr.
  - otherwise (header mismatch): discard, stat_bad_hdr++.
  - Stay IDLE.
- IDLE, sop && !eop: discard, stat_bad_frame++, go to DROP.
- IDLE, !sop: stray beat; discard, stat_bad_frame++. Go to DROP if !eop, else stay IDLE.
- DROP: discard beats silently (no counter change).
  - Accepted eop && !sop: go to IDLE.
  - Accepted sop (resync): handle exactly as in IDLE, including state transition. The abandoned packet is not counted again.
- Latency: frame accepted at edge N produces out_meta_valid=1 with its data after edge N (visible cycle N+1), if the FIFO was empty.
- FIFO: FWFT. out_meta_data always reflects the head entry. Order preserved.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, in_ready=0, so no push can occur.
  - Pointers wrap modulo FIFO_DEPTH.
- in_almost_full = (count ≥ AF_THRESH), registered-count based.
- Stats saturate at 32'hFFFF_FFFF and never wrap.
- Bad frames never touch the FIFO or in_ready.
- Reset mid-packet: FSM returns to IDLE and FIFO contents are lost. The first post-reset non-sop beat counts as stray.

Test Plan:
- Reset, then one good frame with metadata=252'h1234 and out_meta_ready=1 → out_meta_valid rises one cycle after accept, out_meta_data=252'h1234, stat_good=1, other stats 0.
- out_meta_ready=0; send 5 back-to-back good frames with meta 1..5 (DEPTH=4):
  - in_ready drops after the 4th accept; in_almost_full=1 from 2 entries.
  - Releasing ready pops 1,2,3,4, then frame 5 is accepted and popped; stat_good=5.
- Frames with DST_MAC bit flipped and with empty=6'd4 → no output, stat_bad_hdr=1, stat_bad_frame=1.
- 3-beat packet (sop, mid, eop) then a good frame with meta 7 → stat_bad_frame=1, only meta 7 emerges.
- sop-only beat followed directly by a good sop&&eop frame (resync) → stat_bad_frame=1, stat_good=1, good metadata delivered.
- Assert rst low asynchronously with 3 entries queued and FSM in DROP → outputs zero immediately, count=0. After release, a good frame passes normally.
